// File: rtl/buzzer_sequencer.sv
// Piezo tone sequencer for the security-device control FSM.
// Plays the "correct" double beep or the "wrong" long low tone, then pulses done.
module buzzer_sequencer #(
  parameter int HI_HALF   = 25000,
  parameter int LO_HALF   = 50000,
  parameter int SHORT_CYC = 10_000_000,
  parameter int GAP_CYC   = 5_000_000,
  parameter int LONG_CYC  = 40_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] buzzerMode,
  output logic       buzzerDone,
  output logic       buzzer,
  output logic       busy
);

  localparam int DUR_A   = (SHORT_CYC > GAP_CYC) ? SHORT_CYC : GAP_CYC;
  localparam int DUR_MAX = (DUR_A > LONG_CYC) ? DUR_A : LONG_CYC;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int HLF_MAX = (HI_HALF > LO_HALF) ? HI_HALF : LO_HALF;
  localparam int HLF_W   = (HLF_MAX > 1) ? $clog2(HLF_MAX) : 1;

  localparam logic [DUR_W-1:0] SHORT_L = DUR_W'(SHORT_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_L   = DUR_W'(GAP_CYC - 1);
  localparam logic [DUR_W-1:0] LONG_L  = DUR_W'(LONG_CYC - 1);
  localparam logic [HLF_W-1:0] HI_L    = HLF_W'(HI_HALF - 1);
  localparam logic [HLF_W-1:0] LO_L    = HLF_W'(LO_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, BEEP1, GAP, BEEP2, LONG, DONE, HOLD
  } state_t;

  state_t           r_state;
  logic [DUR_W-1:0] r_dur;
  logic [HLF_W-1:0] r_half;
  logic             r_buzzer;
  logic             r_done;
  logic             r_busy;

  logic w_run;
  logic w_dur_end;
  logic w_half_end;

  // Only bit 1 matters for run/stop: 01 is reserved and behaves as off.
  assign w_run = buzzerMode[1];

  always_comb begin
    w_dur_end = 1'b0;
    case (r_state)
      BEEP1, BEEP2: w_dur_end = (r_dur == SHORT_L);
      GAP:          w_dur_end = (r_dur == GAP_L);
      LONG:         w_dur_end = (r_dur == LONG_L);
      default:      w_dur_end = 1'b0;
    endcase
  end

  always_comb begin
    w_half_end = 1'b0;
    if (r_state == LONG)
      w_half_end = (r_half == LO_L);
    else
      w_half_end = (r_half == HI_L);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_dur    <= '0;
      r_half   <= '0;
      r_buzzer <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_run) begin
            r_state  <= buzzerMode[0] ? LONG : BEEP1;
            r_dur    <= '0;
            r_half   <= '0;
            r_buzzer <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        BEEP1, GAP, BEEP2, LONG: begin
          if (!w_run) begin
            r_state  <= IDLE;
            r_dur    <= '0;
            r_half   <= '0;
            r_buzzer <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_dur_end) begin
            r_dur  <= '0;
            r_half <= '0;
            case (r_state)
              BEEP1: begin
                r_state  <= GAP;
                r_buzzer <= 1'b0;
              end
              GAP: begin
                r_state  <= BEEP2;
                r_buzzer <= 1'b1;
              end
              default: begin
                r_state  <= DONE;
                r_buzzer <= 1'b0;
                r_done   <= 1'b1;
              end
            endcase
          end else begin
            r_dur <= r_dur + 1'b1;
            if (r_state != GAP) begin
              if (w_half_end) begin
                r_half   <= '0;
                r_buzzer <= ~r_buzzer;
              end else begin
                r_half <= r_half + 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_state <= HOLD;
          r_busy  <= 1'b0;
        end
        // Wait for the FSM to drop its command so a stale mode cannot retrigger.
        HOLD: begin
          if (!w_run)
            r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_buzzer <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign buzzerDone = r_done;
  assign buzzer     = r_buzzer;
  assign busy       = r_busy;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer.
// Expected {done,busy,buzzer} per cycle is queued and popped after each edge.
module tb_buzzer_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] buzzerMode;
  logic       buzzerDone;
  logic       buzzer;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb[$];

  buzzer_sequencer #(
    .HI_HALF  (2),
    .LO_HALF  (5),
    .SHORT_CYC(8),
    .GAP_CYC  (4),
    .LONG_CYC (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .buzzerMode(buzzerMode),
    .buzzerDone(buzzerDone),
    .buzzer    (buzzer),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic tone(int c, int h);
    return ((c / h) % 2) == 0;
  endfunction

  function automatic logic [2:0] correct_exp(int c);
    if (c < 8)        return {2'b01, tone(c, 2)};
    else if (c < 12)  return 3'b010;
    else if (c < 20)  return {2'b01, tone(c - 12, 2)};
    else if (c == 20) return 3'b110;
    else              return 3'b000;
  endfunction

  function automatic logic [2:0] wrong_exp(int c);
    if (c < 20)       return {2'b01, tone(c, 5)};
    else if (c == 20) return 3'b110;
    else              return 3'b000;
  endfunction

  task automatic test_reset();
    sb.push_back(3'b000);
    checks++;
    begin
      logic [2:0] e;
      e = sb.pop_front();
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL reset got %b want %b", {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_correct();
    logic [1:0] st[$];
    logic [2:0] e;
    for (int c = 0; c < 23; c++) begin
      st.push_back(c <= 20 ? 2'b10 : 2'b00);
      sb.push_back(correct_exp(c));
    end
    for (int i = 0; i < st.size(); i++) begin
      buzzerMode = st[i];
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL correct c%0d got %b want %b", i, {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_wrong();
    logic [1:0] st[$];
    logic [2:0] e;
    for (int c = 0; c < 23; c++) begin
      st.push_back(c <= 20 ? 2'b11 : 2'b00);
      sb.push_back(wrong_exp(c));
    end
    for (int i = 0; i < st.size(); i++) begin
      buzzerMode = st[i];
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL wrong c%0d got %b want %b", i, {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [1:0] st[$];
    logic [2:0] e;
    for (int c = 0; c < 26; c++) begin
      st.push_back(2'b10);
      sb.push_back(correct_exp(c));
    end
    st.push_back(2'b00);
    sb.push_back(3'b000);
    for (int c = 0; c < 23; c++) begin
      st.push_back(c <= 20 ? 2'b11 : 2'b00);
      sb.push_back(wrong_exp(c));
    end
    for (int i = 0; i < st.size(); i++) begin
      buzzerMode = st[i];
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL hold c%0d got %b want %b", i, {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [1:0] st[$];
    logic [2:0] e;
    for (int c = 0; c < 14; c++) begin
      st.push_back(c < 7 ? 2'b11 : 2'b00);
      sb.push_back(c < 7 ? wrong_exp(c) : 3'b000);
    end
    for (int i = 0; i < st.size(); i++) begin
      buzzerMode = st[i];
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL abort c%0d got %b want %b", i, {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int c = 0; c < 10; c++) begin
      sb.push_back(correct_exp(c));
      buzzerMode = 2'b10;
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL rstmid_pre c%0d got %b want %b", c, {buzzerDone, busy, buzzer}, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(3'b000);
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL rstmid_async k%0d got %b want %b", k, {buzzerDone, busy, buzzer}, e);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int c = 0; c < 23; c++) begin
      sb.push_back(correct_exp(c));
      buzzerMode = (c <= 20) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL rstmid_post c%0d got %b want %b", c, {buzzerDone, busy, buzzer}, e);
      end
    end
  endtask

  task automatic test_mode_change();
    logic [1:0] st[$];
    logic [2:0] e;
    for (int c = 0; c < 23; c++) begin
      st.push_back(c < 3 ? 2'b10 : (c <= 20 ? 2'b11 : 2'b00));
      sb.push_back(correct_exp(c));
    end
    for (int c = 0; c < 30; c++) begin
      st.push_back(2'b01);
      sb.push_back(3'b000);
    end
    for (int i = 0; i < st.size(); i++) begin
      buzzerMode = st[i];
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({buzzerDone, busy, buzzer} !== e) begin
        errors++;
        $display("FAIL modechg c%0d got %b want %b", i, {buzzerDone, busy, buzzer}, e);
      end
    end
    buzzerMode = 2'b00;
  endtask

  initial begin
    reset      = 1'b1;
    buzzerMode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_correct();
    test_wrong();
    test_hold();
    test_abort();
    test_reset_mid();
    test_mode_change();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
